// File: rtl/cpu_pkg.sv
// Shared definitions for the parameterised CPU core: opcode encodings,
// FSM state encoding and a small opcode classification helper.
package cpu_pkg;

  localparam logic [3:0] OP_LDI  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_BEQZ = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;
  // Opcodes 10..15 are NOPs.

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Ops 0..7 produce a result, write dst and update the flags.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= OP_SLL;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational execute unit for the CPU core.
// Ports:
//   op_i     opcode of the instruction in EXEC
//   a_i      src1 operand
//   b_i      src2 operand (also the shift amount for SRL/SLL)
//   imm_i    immediate field (LDI)
//   result_o low DATA_W bits of the operation
//   zero_o   result_o == 0
//   carry_o  bit DATA_W of ADD/SUB (SUB: 1 means no borrow), else 0
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              carry_o
);

  localparam logic [DATA_W:0] SHIFT_LIM = (DATA_W+1)'(DATA_W);

  logic [DATA_W:0] sum;
  logic            shift_oob;

  // A shift by DATA_W or more drains every bit out.
  assign shift_oob = {1'b0, b_i} >= SHIFT_LIM;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_LDI: result_o = imm_i;
      OP_MOV: result_o = a_i;
      OP_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_SUB: begin
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_W+1)'(1);
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_SRL: result_o = shift_oob ? '0 : (a_i >> b_i);
      OP_SLL: result_o = shift_oob ? '0 : (a_i << b_i);
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/param_cpu_core.sv
// Parameterised multi-cycle CPU core. One instruction at a time walks
// IDLE -> DECODE -> EXEC -> WB -> IDLE; HALT parks the core until RESET.
// Ports:
//   CLK, RESET   clock (rising edge), asynchronous active-high reset
//   INSTR        instruction word {op, dst, src1, src2, imm}
//   INSTR_VALID  INSTR is valid; INSTR_READY core accepts this cycle (IDLE only)
//   PC           address of the next instruction expected
//   RESULT       last ALU result; ZERO / CARRY flags of the last ALU op
//   DONE         one-cycle pulse when an instruction retires
//   HALTED       core stopped by HALT
//   DBG_ADDR     register index; DBG_DATA its current value (combinational)
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 8,
  parameter  int PC_W    = 9,
  localparam int RA_W    = $clog2(NREGS),
  localparam int INSTR_W = 4 + 3*RA_W + DATA_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  output logic [PC_W-1:0]    PC,
  output logic [DATA_W-1:0]  RESULT,
  output logic               ZERO,
  output logic               CARRY,
  output logic               DONE,
  output logic               HALTED,
  input  logic [RA_W-1:0]    DBG_ADDR,
  output logic [DATA_W-1:0]  DBG_DATA
);

  state_e              state_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   src1_q, src2_q, result_q;
  logic                zero_q, carry_q, done_q, halted_q;
  logic [PC_W-1:0]     pc_q, pc_d;

  // Fields of the captured instruction.
  logic [3:0]          op;
  logic [RA_W-1:0]     dst_a, src1_a, src2_a;
  logic [DATA_W-1:0]   imm;

  assign op     = instr_q[INSTR_W-1 -: 4];
  assign dst_a  = instr_q[INSTR_W-5 -: RA_W];
  assign src1_a = instr_q[INSTR_W-5-RA_W -: RA_W];
  assign src2_a = instr_q[INSTR_W-5-2*RA_W -: RA_W];
  assign imm    = instr_q[DATA_W-1:0];

  logic [DATA_W-1:0] alu_result;
  logic              alu_zero, alu_carry;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op),
    .a_i      (src1_q),
    .b_i      (src2_q),
    .imm_i    (imm),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .carry_o  (alu_carry)
  );

  // Next PC, applied in WB. The size cast zero-extends or truncates imm.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (op == OP_BEQZ && src1_q == '0) pc_d = PC_W'(imm);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      pc_q     <= '0;
      // NOTE: the register file is small flops, not a RAM, so it can and must
      // be cleared by reset like any other state.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, whatever the statement order.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (INSTR_VALID) begin
            instr_q <= INSTR;
            state_q <= ST_DECODE;
          end
        end
        // WB of the previous instruction finished an edge earlier, so this
        // read already sees its write without any bypass.
        ST_DECODE: begin
          src1_q  <= regs_q[src1_a];
          src2_q  <= regs_q[src2_a];
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op == OP_HALT) begin
            halted_q <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            if (is_alu_op(op)) begin
              result_q <= alu_result;
              zero_q   <= alu_zero;
              carry_q  <= alu_carry;
            end
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          if (is_alu_op(op)) regs_q[dst_a] <= result_q;
          pc_q    <= pc_d;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign INSTR_READY = (state_q == ST_IDLE);
  assign PC          = pc_q;
  assign RESULT      = result_q;
  assign ZERO        = zero_q;
  assign CARRY       = carry_q;
  assign DONE        = done_q;
  assign HALTED      = halted_q;
  assign DBG_DATA    = regs_q[DBG_ADDR];

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed, table-driven bench for param_cpu_core at default parameters.
module tb_param_cpu_core;
  import cpu_pkg::*;

  localparam int DATA_W  = 8;
  localparam int RA_W    = 3;
  localparam int PC_W    = 9;
  localparam int INSTR_W = 4 + 3*RA_W + DATA_W;

  logic               CLK;
  logic               RESET;
  logic [INSTR_W-1:0] INSTR;
  logic               INSTR_VALID;
  logic               INSTR_READY;
  logic [PC_W-1:0]    PC;
  logic [DATA_W-1:0]  RESULT;
  logic               ZERO, CARRY, DONE, HALTED;
  logic [RA_W-1:0]    DBG_ADDR;
  logic [DATA_W-1:0]  DBG_DATA;

  param_cpu_core #(.DATA_W(DATA_W), .NREGS(8), .PC_W(PC_W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .PC          (PC),
    .RESULT      (RESULT),
    .ZERO        (ZERO),
    .CARRY       (CARRY),
    .DONE        (DONE),
    .HALTED      (HALTED),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_DATA    (DBG_DATA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [2:0] d,
                                             input logic [2:0] s1, input logic [2:0] s2,
                                             input logic [7:0] im);
    return {op, d, s1, s2, im};
  endfunction

  task automatic read_reg(input logic [2:0] a, output logic [DATA_W-1:0] v);
    DBG_ADDR = a;
    #1;
    v = DBG_DATA;
  endtask

  // Issue one instruction from a negedge; returns DONE sampled at the
  // negedges after accept edges N, N+1, N+2, N+3 (expected 4'b0001).
  task automatic issue(input logic [INSTR_W-1:0] w, output logic [3:0] pat);
    int waited;
    pat = '0;
    INSTR = w;
    INSTR_VALID = 1'b1;
    waited = 0;
    while (!INSTR_READY && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    check("accept_ready", {31'd0, INSTR_READY}, 32'd1);
    if (!INSTR_READY) begin
      INSTR_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    for (int k = 3; k >= 0; k--) begin
      @(negedge CLK);
      INSTR_VALID = 1'b0;
      INSTR = INSTR_W'($urandom);
      pat[k] = DONE;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  dst, s1, s2;
    logic [7:0]  imm;
    logic [2:0]  chk_reg;
    logic [7:0]  exp_reg;
    logic [7:0]  exp_res;
    logic        exp_z, exp_c;
    logic [8:0]  exp_pc;
  } vec_t;

  vec_t vecs[23];

  logic [3:0]        pat;
  logic [DATA_W-1:0] rv;
  int                cnt;
  logic              bad;

  initial begin
    //           name        op       d  s1 s2 imm    chk  reg    res    z  c  pc
    vecs[0]  = '{"ldi_r1",   OP_LDI,  1, 0, 0, 8'h05, 1, 8'h05, 8'h05, 0, 0, 9'd1};
    vecs[1]  = '{"ldi_r2",   OP_LDI,  2, 0, 0, 8'h03, 2, 8'h03, 8'h03, 0, 0, 9'd2};
    vecs[2]  = '{"add_8",    OP_ADD,  3, 1, 2, 8'h00, 3, 8'h08, 8'h08, 0, 0, 9'd3};
    vecs[3]  = '{"ldi_ff",   OP_LDI,  1, 0, 0, 8'hFF, 1, 8'hFF, 8'hFF, 0, 0, 9'd4};
    vecs[4]  = '{"ldi_1",    OP_LDI,  2, 0, 0, 8'h01, 2, 8'h01, 8'h01, 0, 0, 9'd5};
    vecs[5]  = '{"add_wrap", OP_ADD,  4, 1, 2, 8'h00, 4, 8'h00, 8'h00, 1, 1, 9'd6};
    vecs[6]  = '{"sub_eq",   OP_SUB,  5, 2, 2, 8'h00, 5, 8'h00, 8'h00, 1, 1, 9'd7};
    vecs[7]  = '{"sub_brw",  OP_SUB,  5, 2, 1, 8'h00, 5, 8'h02, 8'h02, 0, 0, 9'd8};
    vecs[8]  = '{"and",      OP_AND,  6, 1, 3, 8'h00, 6, 8'h08, 8'h08, 0, 0, 9'd9};
    vecs[9]  = '{"or",       OP_OR,   6, 3, 2, 8'h00, 6, 8'h09, 8'h09, 0, 0, 9'd10};
    vecs[10] = '{"ldi_80",   OP_LDI,  1, 0, 0, 8'h80, 1, 8'h80, 8'h80, 0, 0, 9'd11};
    vecs[11] = '{"ldi_3",    OP_LDI,  7, 0, 0, 8'h03, 7, 8'h03, 8'h03, 0, 0, 9'd12};
    vecs[12] = '{"srl_3",    OP_SRL,  6, 1, 7, 8'h00, 6, 8'h10, 8'h10, 0, 0, 9'd13};
    vecs[13] = '{"ldi_8",    OP_LDI,  7, 0, 0, 8'h08, 7, 8'h08, 8'h08, 0, 0, 9'd14};
    vecs[14] = '{"sll_8",    OP_SLL,  6, 1, 7, 8'h00, 6, 8'h00, 8'h00, 1, 0, 9'd15};
    vecs[15] = '{"nop",      4'd12,   6, 1, 2, 8'h55, 6, 8'h00, 8'h00, 1, 0, 9'd16};
    vecs[16] = '{"srl_1",    OP_SRL,  6, 1, 2, 8'h00, 6, 8'h40, 8'h40, 0, 0, 9'd17};
    vecs[17] = '{"mov",      OP_MOV,  5, 3, 0, 8'h00, 5, 8'h08, 8'h08, 0, 0, 9'd18};
    vecs[18] = '{"add_c",    OP_ADD,  7, 1, 1, 8'h00, 7, 8'h00, 8'h00, 1, 1, 9'd19};
    vecs[19] = '{"beqz_tk",  OP_BEQZ, 3, 0, 0, 8'hF0, 3, 8'h08, 8'h00, 1, 1, 9'h0F0};
    vecs[20] = '{"beqz_nt",  OP_BEQZ, 3, 1, 0, 8'h22, 3, 8'h08, 8'h00, 1, 1, 9'h0F1};
    vecs[21] = '{"sub_81",   OP_SUB,  6, 2, 1, 8'h00, 6, 8'h81, 8'h81, 0, 0, 9'h0F2};
    vecs[22] = '{"beqz_ff",  OP_BEQZ, 6, 4, 0, 8'hFF, 6, 8'h81, 8'h81, 0, 0, 9'h0FF};

    RESET = 1'b1;
    INSTR = '0;
    INSTR_VALID = 1'b0;
    DBG_ADDR = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // Reset state.
    check("rst_ready",  {31'd0, INSTR_READY}, 32'd1);
    check("rst_pc",     {23'd0, PC}, 32'd0);
    check("rst_result", {24'd0, RESULT}, 32'd0);
    check("rst_zero",   {31'd0, ZERO}, 32'd1);
    check("rst_carry",  {31'd0, CARRY}, 32'd0);
    check("rst_done",   {31'd0, DONE}, 32'd0);
    check("rst_halted", {31'd0, HALTED}, 32'd0);
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), rv);
      check("rst_reg", {24'd0, rv}, 32'd0);
    end
    @(negedge CLK);

    // Table-driven program.
    for (int i = 0; i < 23; i++) begin
      issue(enc(vecs[i].op, vecs[i].dst, vecs[i].s1, vecs[i].s2, vecs[i].imm), pat);
      check({vecs[i].name, "_done"}, {28'd0, pat}, 32'b0001);
      read_reg(vecs[i].chk_reg, rv);
      check({vecs[i].name, "_reg"},    {24'd0, rv}, {24'd0, vecs[i].exp_reg});
      check({vecs[i].name, "_result"}, {24'd0, RESULT}, {24'd0, vecs[i].exp_res});
      check({vecs[i].name, "_zero"},   {31'd0, ZERO}, {31'd0, vecs[i].exp_z});
      check({vecs[i].name, "_carry"},  {31'd0, CARRY}, {31'd0, vecs[i].exp_c});
      check({vecs[i].name, "_pc"},     {23'd0, PC}, {23'd0, vecs[i].exp_pc});
      @(negedge CLK);
      #0;
    end

    // PC wrap: 256 NOPs from 0xFF reach 0x1FF, then an ADD wraps PC to 0.
    for (int i = 0; i < 256; i++) issue(enc(4'd10, 0, 0, 0, 8'h00), pat);
    check("pc_1ff", {23'd0, PC}, 32'h1FF);
    issue(enc(OP_ADD, 3, 2, 2, 8'h00), pat);
    check("wrap_done", {28'd0, pat}, 32'b0001);
    check("wrap_pc", {23'd0, PC}, 32'd0);
    read_reg(3, rv);
    check("wrap_reg", {24'd0, rv}, 32'd2);
    check("wrap_zero", {31'd0, ZERO}, 32'd0);

    // Reset in EXEC of ADD r6: no write, no DONE, ready right after release.
    issue(enc(OP_LDI, 1, 0, 0, 8'h05), pat);
    INSTR = enc(OP_ADD, 6, 1, 1, 8'h00);
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    INSTR_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    bad = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (DONE) bad = 1'b1;
    end
    RESET = 1'b0;
    check("midrst_ready", {31'd0, INSTR_READY}, 32'd1);
    repeat (6) begin
      @(negedge CLK);
      if (DONE) bad = 1'b1;
    end
    check("midrst_no_done", {31'd0, bad}, 32'd0);
    read_reg(6, rv);
    check("midrst_r6", {24'd0, rv}, 32'd0);
    check("midrst_pc", {23'd0, PC}, 32'd0);
    @(negedge CLK);

    // HALT: one DONE, HALTED set, PC held, never ready with VALID held high.
    issue(enc(OP_LDI, 1, 0, 0, 8'h07), pat);
    INSTR = enc(OP_HALT, 0, 0, 0, 8'h00);
    INSTR_VALID = 1'b1;
    @(posedge CLK);
    cnt = 0;
    repeat (6) begin
      @(negedge CLK);
      if (DONE) cnt++;
    end
    check("halt_done_pulses", 32'(cnt), 32'd1);
    check("halt_halted", {31'd0, HALTED}, 32'd1);
    check("halt_pc", {23'd0, PC}, 32'd1);
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      INSTR = enc(OP_LDI, 2, 0, 0, 8'h33);
      if (INSTR_READY || !HALTED || DONE) bad = 1'b1;
    end
    check("halt_hold", {31'd0, bad}, 32'd0);
    read_reg(2, rv);
    check("halt_no_write", {24'd0, rv}, 32'd0);
    INSTR_VALID = 1'b0;
    do_reset();
    check("unhalt_halted", {31'd0, HALTED}, 32'd0);
    check("unhalt_pc", {23'd0, PC}, 32'd0);
    check("unhalt_ready", {31'd0, INSTR_READY}, 32'd1);
    read_reg(1, rv);
    check("unhalt_r1", {24'd0, rv}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
